next_hop_selector: RTL and testbench
====================================

// Module: next_hop_selector
// PURPOSE
//  Parametrised next-hop decision engine for cluster-member (role 0) nodes in the EER-RL routing core.
//  - Short-circuits to the sink or to the chosen cluster head (CH) when the node is one hop away.
//  - Otherwise scans a streamed neighbour table, filters it by hop gradient and residual energy,
//    and registers the neighbour with the highest Q-value.
//  Sits between the neighbour-table memory and the packet-forwarding unit.
// PARAMETERS
//  ID_W          8   node ID width
//  HOP_W         8   hop-count width
//  Q_W           16  Q-value width (unsigned)
//  E_W           16  energy width (unsigned)
//  MAX_NEIGHBORS 16  max table beats evaluated per decision
//  SINK_ID       0   ID returned when the node is one hop from the sink
//  CNT_W = $clog2(MAX_NEIGHBORS+1)  (localparam)
// PORTS
//  clk          in   1      single clock, rising edge
//  rst          in   1      synchronous, active-high reset
//  start        in   1      1-cycle request; inputs below are sampled with it
//  my_hops_sink in   HOP_W  own hop count to the sink
//  my_hops_ch   in   HOP_W  own hop count to the chosen CH
//  chosen_ch    in   ID_W   chosen CH ID
//  min_energy   in   E_W    energy floor for candidates
//  nb_valid     in   1      neighbour beat valid
//  nb_ready     out  1      selector accepts a beat
//  nb_id        in   ID_W   neighbour ID
//  nb_hops_ch   in   HOP_W  neighbour hop count to the CH
//  nb_qvalue    in   Q_W    neighbour Q-value
//  nb_energy    in   E_W    neighbour residual energy
//  nb_last      in   1      final beat of the table
//  busy         out  1      decision in progress
//  out_valid    out  1      1-cycle result strobe
//  next_hop     out  ID_W   selected next hop (held until the next start)
//  route_found  out  1      1 = next_hop is a valid route
//  overflow     out  1      more than MAX_NEIGHBORS beats were seen
//  cand_count   out  CNT_W  number of qualifying candidates
// BEHAVIOUR
//  Reset:
//  - State to IDLE.
//  - All outputs 0: nb_ready, busy, out_valid, next_hop, route_found, overflow, cand_count.
//  FSM IDLE -> SCAN -> DONE -> IDLE.
//  IDLE:
//  - On start, latch my_hops_sink, my_hops_ch, chosen_ch and min_energy; clear best, count and overflow.
//  - If my_hops_sink==1: go to DONE with next_hop=SINK_ID, route_found=1.
//  - Else if my_hops_ch<=1 (0 avoids underflow): go to DONE with next_hop=chosen_ch, route_found=1.
//  - Else: go to SCAN.
//  - start is ignored while busy=1.
//  SCAN:
//  - nb_ready=1. A beat is accepted when nb_valid and nb_ready are both 1.
//  - A beat qualifies iff nb_hops_ch==my_hops_ch-1 and nb_energy>=min_energy.
//  - A qualifying beat replaces best iff no best is held yet or nb_qvalue>best_q (strict).
//  - Ties keep the earlier beat. Q=0 is selectable.
//  - Accepted beats beyond the MAX_NEIGHBORS-th are consumed but not evaluated; they set overflow=1.
//  - cand_count saturates at MAX_NEIGHBORS.
//  - An accepted beat with nb_last=1 moves to DONE.
//  DONE (1 cycle):
//  - out_valid=1.
//  - Scan path with a held best: next_hop=best_id, route_found=1.
//  - Scan path with no candidate: next_hop=chosen_ch, route_found=0.
//  - Then IDLE. A start in the DONE cycle is ignored.
//  Latency:
//  - Short-circuit: out_valid exactly 1 cycle after start.
//  - Scan: out_valid exactly 1 cycle after the nb_last handshake.
//  busy=1 in SCAN and DONE.
//  next_hop, route_found, overflow and cand_count hold after DONE; they are cleared on the next accepted start.
//  rst mid-SCAN: the decision is aborted, no out_valid, outputs return to reset values.
// TESTING
//  1. start, my_hops_sink=1 -> out_valid @+1, next_hop=SINK_ID, route_found=1, nb_ready never 1.
//  2. start, my_hops_sink=3, my_hops_ch=1, chosen_ch=0x22 -> @+1 next_hop=0x22, route_found=1.
//  3. my_hops_ch=3, min_energy=100, beats (id,hops,q,e): (5,2,40,200) (6,2,90,50) (7,1,99,300) (8,2,60,150, last)
//     -> next_hop=8, cand_count=2, route_found=1.
//  4. my_hops_ch=3, beats (9,2,70,200) (10,2,70,200, last) -> next_hop=9 (tie keeps first).
//     Repeat with nb_valid gapped every other cycle -> same result.
//  5. my_hops_ch=4, no beat with hops 3, chosen_ch=0x11 -> next_hop=0x11, route_found=0, cand_count=0.
//  6. MAX_NEIGHBORS=4: 6 beats, best at beat 5 -> overflow=1, best among beats 1-4.
//     Separately, rst at beat 2 -> no out_valid, all outputs 0.

Source files
------------

// File: rtl/next_hop_selector.sv
// next_hop_selector: next-hop decision engine for cluster-member nodes.
// A request either short-circuits straight to the sink or the chosen cluster
// head, or scans a streamed neighbour table and keeps the qualifying
// neighbour with the highest Q-value.
module next_hop_selector #(
   parameter int ID_W          = 8,
   parameter int HOP_W         = 8,
   parameter int Q_W           = 16,
   parameter int E_W           = 16,
   parameter int MAX_NEIGHBORS = 16,
   parameter int SINK_ID       = 0,
   localparam int CNT_W        = $clog2(MAX_NEIGHBORS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [HOP_W-1:0] my_hops_sink,
   input  logic [HOP_W-1:0] my_hops_ch,
   input  logic [ID_W-1:0]  chosen_ch,
   input  logic [E_W-1:0]   min_energy,
   input  logic             nb_valid,
   output logic             nb_ready,
   input  logic [ID_W-1:0]  nb_id,
   input  logic [HOP_W-1:0] nb_hops_ch,
   input  logic [Q_W-1:0]   nb_qvalue,
   input  logic [E_W-1:0]   nb_energy,
   input  logic             nb_last,
   output logic             busy,
   output logic             out_valid,
   output logic [ID_W-1:0]  next_hop,
   output logic             route_found,
   output logic             overflow,
   output logic [CNT_W-1:0] cand_count
);

   localparam logic [ID_W-1:0]  SINK_ID_L = ID_W'(SINK_ID);
   localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_NEIGHBORS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SCAN,
      S_DONE
   } state_t;

   // Control state and registered outputs
   state_t           state_q,       state_d;
   logic             nb_ready_q,    nb_ready_d;
   logic             busy_q,        busy_d;
   logic             out_valid_q,   out_valid_d;
   logic [ID_W-1:0]  next_hop_q,    next_hop_d;
   logic             route_found_q, route_found_d;
   logic             overflow_q,    overflow_d;
   logic [CNT_W-1:0] cand_count_q,  cand_count_d;
   logic [CNT_W-1:0] beat_cnt_q,    beat_cnt_d;
   logic             has_best_q,    has_best_d;

   // Request context latched at start and running best candidate
   logic [HOP_W-1:0] hops_ch_q,  hops_ch_d;
   logic [ID_W-1:0]  ch_id_q,    ch_id_d;
   logic [E_W-1:0]   min_e_q,    min_e_d;
   logic [ID_W-1:0]  best_id_q,  best_id_d;
   logic [Q_W-1:0]   best_qv_q,  best_qv_d;

   logic             beat_acc;
   logic             beat_eval;
   logic             beat_qual;
   logic             beat_take;
   logic [HOP_W-1:0] target_hops;

   assign nb_ready    = nb_ready_q;
   assign busy        = busy_q;
   assign out_valid   = out_valid_q;
   assign next_hop    = next_hop_q;
   assign route_found = route_found_q;
   assign overflow    = overflow_q;
   assign cand_count  = cand_count_q;

   // Beat classification: accepted, evaluated (within table budget), qualifying, new best
   always_comb begin
      target_hops = hops_ch_q - 1'b1;
      beat_acc    = nb_valid && nb_ready_q;
      beat_eval   = beat_acc && (beat_cnt_q < MAX_CNT);
      beat_qual   = beat_eval && (nb_hops_ch == target_hops) && (nb_energy >= min_e_q);
      beat_take   = beat_qual && (!has_best_q || (nb_qvalue > best_qv_q));
   end

   // Next-state and next-output computation for the IDLE -> SCAN -> DONE decision
   always_comb begin
      state_d       = state_q;
      out_valid_d   = 1'b0;
      next_hop_d    = next_hop_q;
      route_found_d = route_found_q;
      overflow_d    = overflow_q;
      cand_count_d  = cand_count_q;
      beat_cnt_d    = beat_cnt_q;
      has_best_d    = has_best_q;
      hops_ch_d     = hops_ch_q;
      ch_id_d       = ch_id_q;
      min_e_d       = min_e_q;
      best_id_d     = best_id_q;
      best_qv_d     = best_qv_q;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               hops_ch_d     = my_hops_ch;
               ch_id_d       = chosen_ch;
               min_e_d       = min_energy;
               has_best_d    = 1'b0;
               beat_cnt_d    = '0;
               cand_count_d  = '0;
               overflow_d    = 1'b0;
               if (my_hops_sink == HOP_W'(1)) begin
                  state_d       = S_DONE;
                  out_valid_d   = 1'b1;
                  next_hop_d    = SINK_ID_L;
                  route_found_d = 1'b1;
               end else if (my_hops_ch <= HOP_W'(1)) begin
                  // hop count 0 also short-circuits so the scan target never underflows
                  state_d       = S_DONE;
                  out_valid_d   = 1'b1;
                  next_hop_d    = chosen_ch;
                  route_found_d = 1'b1;
               end else begin
                  state_d       = S_SCAN;
                  next_hop_d    = '0;
                  route_found_d = 1'b0;
               end
            end
         end

         S_SCAN: begin
            if (beat_acc) begin
               if (beat_eval) begin
                  beat_cnt_d = beat_cnt_q + 1'b1;
               end else begin
                  overflow_d = 1'b1;
               end
               if (beat_qual && (cand_count_q != MAX_CNT)) begin
                  cand_count_d = cand_count_q + 1'b1;
               end
               if (beat_take) begin
                  has_best_d = 1'b1;
                  best_id_d  = nb_id;
                  best_qv_d  = nb_qvalue;
               end
               if (nb_last) begin
                  state_d     = S_DONE;
                  out_valid_d = 1'b1;
                  // the final beat itself may be the winner, so look at it directly
                  if (beat_take) begin
                     next_hop_d    = nb_id;
                     route_found_d = 1'b1;
                  end else if (has_best_q) begin
                     next_hop_d    = best_id_q;
                     route_found_d = 1'b1;
                  end else begin
                     next_hop_d    = ch_id_q;
                     route_found_d = 1'b0;
                  end
               end
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Handshake/status flags follow the next state so they are registered outputs
   always_comb begin
      busy_d     = (state_d != S_IDLE);
      nb_ready_d = (state_d == S_SCAN);
   end

   // Control and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         nb_ready_q    <= 1'b0;
         busy_q        <= 1'b0;
         out_valid_q   <= 1'b0;
         next_hop_q    <= '0;
         route_found_q <= 1'b0;
         overflow_q    <= 1'b0;
         cand_count_q  <= '0;
         beat_cnt_q    <= '0;
         has_best_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         nb_ready_q    <= nb_ready_d;
         busy_q        <= busy_d;
         out_valid_q   <= out_valid_d;
         next_hop_q    <= next_hop_d;
         route_found_q <= route_found_d;
         overflow_q    <= overflow_d;
         cand_count_q  <= cand_count_d;
         beat_cnt_q    <= beat_cnt_d;
         has_best_q    <= has_best_d;
      end
   end

   // Data registers: only meaningful once qualified by control state, so no reset
   always_ff @(posedge clk) begin
      hops_ch_q <= hops_ch_d;
      ch_id_q   <= ch_id_d;
      min_e_q   <= min_e_d;
      best_id_q <= best_id_d;
      best_qv_q <= best_qv_d;
   end

endmodule

// File: tb/tb_next_hop_selector.sv
// Bench for next_hop_selector: directed cases plus randomized decisions
// compared against a list-based reference model of the selection rules.
module tb_next_hop_selector;

   localparam int ID_W  = 8;
   localparam int HOP_W = 8;
   localparam int Q_W   = 16;
   localparam int E_W   = 16;
   localparam int MAXN  = 4;
   localparam int SINK  = 8'h3C;
   localparam int CNT_W = $clog2(MAXN + 1);

   typedef struct {
      int id;
      int hops;
      int q;
      int e;
   } beat_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [HOP_W-1:0] my_hops_sink = '0;
   logic [HOP_W-1:0] my_hops_ch = '0;
   logic [ID_W-1:0]  chosen_ch = '0;
   logic [E_W-1:0]   min_energy = '0;
   logic             nb_valid = 1'b0;
   logic             nb_ready;
   logic [ID_W-1:0]  nb_id = '0;
   logic [HOP_W-1:0] nb_hops_ch = '0;
   logic [Q_W-1:0]   nb_qvalue = '0;
   logic [E_W-1:0]   nb_energy = '0;
   logic             nb_last = 1'b0;
   logic             busy;
   logic             out_valid;
   logic [ID_W-1:0]  next_hop;
   logic             route_found;
   logic             overflow;
   logic [CNT_W-1:0] cand_count;

   int checks = 0;
   int errors = 0;
   beat_t beats[$];

   next_hop_selector #(
      .ID_W(ID_W), .HOP_W(HOP_W), .Q_W(Q_W), .E_W(E_W),
      .MAX_NEIGHBORS(MAXN), .SINK_ID(SINK)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .my_hops_sink(my_hops_sink), .my_hops_ch(my_hops_ch),
      .chosen_ch(chosen_ch), .min_energy(min_energy),
      .nb_valid(nb_valid), .nb_ready(nb_ready), .nb_id(nb_id),
      .nb_hops_ch(nb_hops_ch), .nb_qvalue(nb_qvalue), .nb_energy(nb_energy),
      .nb_last(nb_last), .busy(busy), .out_valid(out_valid),
      .next_hop(next_hop), .route_found(route_found),
      .overflow(overflow), .cand_count(cand_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ready"}, 32'(nb_ready), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_ovalid"}, 32'(out_valid), 0);
      chk({tag, "_hop"}, 32'(next_hop), 0);
      chk({tag, "_found"}, 32'(route_found), 0);
      chk({tag, "_ovf"}, 32'(overflow), 0);
      chk({tag, "_cnt"}, 32'(cand_count), 0);
   endtask

   // Short-circuit request; optionally fires another start during the DONE cycle
   task automatic run_short(input string tag, input int sink, input int ch, input int cid,
                            input bit poke_done);
      int exp_hop;
      exp_hop = (sink == 1) ? SINK : cid;
      @(negedge clk);
      start = 1'b1; my_hops_sink = HOP_W'(sink); my_hops_ch = HOP_W'(ch);
      chosen_ch = ID_W'(cid); min_energy = E_W'(7);
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_ovalid"}, 32'(out_valid), 1);
      chk({tag, "_hop"}, 32'(next_hop), 32'(exp_hop));
      chk({tag, "_found"}, 32'(route_found), 1);
      chk({tag, "_ready"}, 32'(nb_ready), 0);
      chk({tag, "_busy"}, 32'(busy), 1);
      chk({tag, "_cnt"}, 32'(cand_count), 0);
      chk({tag, "_ovf"}, 32'(overflow), 0);
      if (poke_done) begin
         start = 1'b1; my_hops_sink = HOP_W'(1);
      end
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_ovalid_drop"}, 32'(out_valid), 0);
      chk({tag, "_busy_drop"}, 32'(busy), 0);
      chk({tag, "_hop_hold"}, 32'(next_hop), 32'(exp_hop));
      @(negedge clk);
      chk({tag, "_ready_idle"}, 32'(nb_ready), 0);
      chk({tag, "_ovalid_idle"}, 32'(out_valid), 0);
   endtask

   // Scan request over the beats queue, expected result from the reference model
   task automatic run_scan(input string tag, input int ch, input int cid, input int mine,
                           input bit gapped, input bit poke_busy);
      int  exp_hop, exp_cnt, best_q, w;
      bit  exp_found, exp_ovf;
      exp_found = 0; exp_cnt = 0; best_q = 0; exp_hop = cid;
      for (int i = 0; i < beats.size() && i < MAXN; i++) begin
         if (beats[i].hops == ch - 1 && beats[i].e >= mine) begin
            exp_cnt++;
            if (!exp_found || beats[i].q > best_q) begin
               exp_found = 1; best_q = beats[i].q; exp_hop = beats[i].id;
            end
         end
      end
      exp_ovf = (beats.size() > MAXN);

      @(negedge clk);
      start = 1'b1; my_hops_sink = HOP_W'(5); my_hops_ch = HOP_W'(ch);
      chosen_ch = ID_W'(cid); min_energy = E_W'(mine);
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_scan_ready"}, 32'(nb_ready), 1);
      chk({tag, "_scan_busy"}, 32'(busy), 1);
      for (int i = 0; i < beats.size(); i++) begin
         if (gapped) begin
            nb_valid = 1'b0;
            if (poke_busy) begin
               start = 1'b1; my_hops_sink = HOP_W'(1);
            end
            @(negedge clk);
            start = 1'b0;
            chk({tag, "_gap_ovalid"}, 32'(out_valid), 0);
         end
         nb_valid = 1'b1; nb_id = ID_W'(beats[i].id); nb_hops_ch = HOP_W'(beats[i].hops);
         nb_qvalue = Q_W'(beats[i].q); nb_energy = E_W'(beats[i].e);
         nb_last = (i == beats.size() - 1);
         w = 0;
         while (nb_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
         end
         if (w >= 20) chk({tag, "_ready_timeout"}, 32'(nb_ready), 1);
         @(negedge clk);
         nb_valid = 1'b0; nb_last = 1'b0;
      end
      chk({tag, "_ovalid"}, 32'(out_valid), 1);
      chk({tag, "_hop"}, 32'(next_hop), 32'(exp_hop));
      chk({tag, "_found"}, 32'(route_found), 32'(exp_found));
      chk({tag, "_cnt"}, 32'(cand_count), 32'(exp_cnt));
      chk({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
      chk({tag, "_done_ready"}, 32'(nb_ready), 0);
      @(negedge clk);
      chk({tag, "_ovalid_drop"}, 32'(out_valid), 0);
      chk({tag, "_busy_drop"}, 32'(busy), 0);
      chk({tag, "_hop_hold"}, 32'(next_hop), 32'(exp_hop));
      chk({tag, "_cnt_hold"}, 32'(cand_count), 32'(exp_cnt));
   endtask

   function automatic beat_t mk(input int id, input int hops, input int q, input int e);
      beat_t b;
      b.id = id; b.hops = hops; b.q = q; b.e = e;
      return b;
   endfunction

   initial begin
      int mode, ch, n, mine;

      // Reset state
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b0;

      // One hop from the sink
      run_short("t1_sink", 1, 4, 8'h22, 1'b0);
      // One hop from the CH, and a start fired in the DONE cycle
      run_short("t2_ch", 3, 1, 8'h22, 1'b1);
      // Zero hops to CH also short-circuits
      run_short("t2_ch0", 2, 0, 8'h5A, 1'b0);

      // Filtered scan
      beats = {mk(5, 2, 40, 200), mk(6, 2, 90, 50), mk(7, 1, 99, 300), mk(8, 2, 60, 150)};
      run_scan("t3_filter", 3, 8'h11, 100, 1'b0, 1'b0);

      // Tie keeps the first, contiguous and gapped, with start pokes while busy
      beats = {mk(9, 2, 70, 200), mk(10, 2, 70, 200)};
      run_scan("t4_tie", 3, 8'h11, 100, 1'b0, 1'b0);
      run_scan("t4_tie_gap", 3, 8'h11, 100, 1'b1, 1'b1);

      // Q=0 is still selectable
      beats = {mk(12, 1, 5, 200), mk(13, 2, 0, 100)};
      run_scan("t4_q0", 3, 8'h11, 100, 1'b0, 1'b0);

      // No qualifying neighbour
      beats = {mk(20, 2, 50, 500), mk(21, 4, 60, 500), mk(22, 3, 70, 10)};
      run_scan("t5_none", 4, 8'h11, 100, 1'b0, 1'b0);

      // Overflow: best beyond the table budget is ignored
      beats = {mk(1, 2, 10, 200), mk(2, 2, 30, 200), mk(3, 2, 20, 200),
               mk(4, 2, 25, 200), mk(5, 2, 99, 200), mk(6, 2, 5, 200)};
      run_scan("t6_ovf", 3, 8'h11, 100, 1'b0, 1'b0);

      // Reset mid-scan aborts the decision
      @(negedge clk);
      start = 1'b1; my_hops_sink = HOP_W'(5); my_hops_ch = HOP_W'(3);
      chosen_ch = ID_W'(8'h11); min_energy = E_W'(100);
      @(negedge clk);
      start = 1'b0;
      nb_valid = 1'b1; nb_id = 8'd1; nb_hops_ch = 8'd2; nb_qvalue = 16'd10; nb_energy = 16'd200;
      @(negedge clk);
      chk("t6_rst_precnt", 32'(cand_count), 1);
      nb_id = 8'd2; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; nb_valid = 1'b0;
      chk_all_zero("t6_rst");
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("t6_rst_noval", 32'(out_valid), 0);
      end

      // Randomized decisions
      for (int it = 0; it < 40; it++) begin
         mode = int'($urandom_range(0, 4));
         if (mode == 0) begin
            if ($urandom_range(0, 1) == 1)
               run_short("rnd_short", 1, int'($urandom_range(0, 6)), int'($urandom_range(0, 255)), 1'b0);
            else
               run_short("rnd_short", int'($urandom_range(2, 9)), int'($urandom_range(0, 1)),
                         int'($urandom_range(0, 255)), 1'b1);
         end else begin
            ch   = int'($urandom_range(2, 5));
            n    = int'($urandom_range(1, 6));
            mine = int'($urandom_range(50, 150));
            beats.delete();
            for (int b = 0; b < n; b++)
               beats.push_back(mk(int'($urandom_range(1, 255)), int'($urandom_range(ch - 2, ch)),
                                  int'($urandom_range(0, 7)), int'($urandom_range(0, 255))));
            run_scan("rnd_scan", ch, int'($urandom_range(0, 255)), mine,
                     bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
